// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg
// Shared types and constants for the direct-mapped instruction cache.
// The types describe the default configuration (16 one-word frames):
// 26-bit tag, 4-bit index, 2-bit byte offset.
// Also holds the saturating-increment helper used by the perf counters.

package icache_dm_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  // Fetch address as seen by the cache.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icache_addr_t;

  // One direct-mapped frame.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  // IDLE answers lookups; FETCH waits on the controller for one refill word.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] satIncrement(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/icache_dm_sat_counter.sv
// sat_counter32
// Enable-gated 32-bit event counter that saturates at 32'hFFFF_FFFF.
// Ports:
//   clk_i   - clock, counts on rising edge
//   rst_ni  - asynchronous active-low reset, clears the count
//   en_i    - count this cycle
//   count_o - current count

module sat_counter32
  import icache_dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next value: hold unless enabled; the helper keeps a full counter pinned.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = satIncrement(count_q);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/icache_dm.sv
// icache_dm
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally from stored frames; a miss latches the
// word address and issues a single-word refill, stalling fetch until the
// refill lands. The next cycle re-looks up the (possibly new) fetch address.
// Ports:
//   CLK, nRST            - clock, asynchronous active-low reset
//   imemREN, imemaddr    - fetch request and byte address from the datapath
//   ihit, imemload       - hit flag and instruction word back to the datapath
//   iREN, iaddr          - refill request and word-aligned address to memory
//   iwait, iload         - controller busy flag and refill data
//   hit_count            - saturating count of hit cycles
//   miss_count           - saturating count of misses taken

module icache_dm
  import icache_dm_pkg::*;
#(
  parameter  int SETS  = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  icache_state_t state_q, state_d;

  // Word address (byte offset dropped) of the refill in flight.
  logic [29:0] missAddr_q, missAddr_d;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] missTag;
  logic [IDX_W-1:0] missIdx;
  logic             lookupHit;
  logic             refillWe;
  logic             missTaken;
  logic [1:0]       unusedOffset;

  assign reqTag  = imemaddr[31:2+IDX_W];
  assign reqIdx  = imemaddr[1+IDX_W:2];
  assign missTag = missAddr_q[29:IDX_W];
  assign missIdx = missAddr_q[IDX_W-1:0];

  // Fetches are word aligned; the byte offset never takes part in lookup.
  assign unusedOffset = imemaddr[1:0];

  assign lookupHit = imemREN && valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);

  // Next-state and outputs. The refill side (iREN/iaddr) depends only on
  // registered state, so a fetch-address change never reaches the memory
  // controller combinationally. Refill data is not forwarded: hits only ever
  // come from frames already written.
  always_comb begin
    state_d    = state_q;
    missAddr_d = missAddr_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    refillWe   = 1'b0;
    missTaken  = 1'b0;

    case (state_q)
      IDLE: begin
        if (lookupHit) begin
          ihit     = 1'b1;
          imemload = data_q[reqIdx];
        end else if (imemREN) begin
          missAddr_d = imemaddr[31:2];
          missTaken  = 1'b1;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        // The refill always finishes for the latched address, even if the
        // datapath redirects or drops its request meanwhile.
        iREN  = 1'b1;
        iaddr = {missAddr_q, 2'b00};
        if (!iwait) begin
          refillWe = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state; reset mid-refill drops the request immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      missAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      missAddr_q <= missAddr_d;
    end
  end

  // Valid bits are the only frame state that needs reset; an abandoned
  // refill never sets one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (refillWe) begin
      valid_q[missIdx] <= 1'b1;
    end
  end

  // Tag and data storage; a refill simply overwrites whatever the frame held.
  always_ff @(posedge CLK) begin
    if (refillWe) begin
      tag_q[missIdx]  <= missTag;
      data_q[missIdx] <= iload;
    end
  end

  sat_counter32 u_hitCounter (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (ihit),
    .count_o (hit_count)
  );

  sat_counter32 u_missCounter (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (missTaken),
    .count_o (miss_count)
  );

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm
// Self-checking bench for icache_dm. A behavioural model keeps a byte-address
// keyed memory image and a 16-entry direct-mapped table computed with plain
// divide/modulo arithmetic; the bench plays the memory controller.

module tb_icache_dm;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks;
  int errors;
  int expHits;
  int expMisses;

  logic [31:0] memModel [int unsigned];
  bit          mValid [16];
  logic [31:0] mTag   [16];
  logic [31:0] mData  [16];

  icache_dm dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backing memory: every word gets a random value the first time it is read.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    int unsigned key;
    key = a >> 2;
    if (!memModel.exists(key)) begin
      memModel[key] = $urandom;
    end
    return memModel[key];
  endfunction

  function automatic int modelIdx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    int idx;
    idx = modelIdx(a);
    return mValid[idx] && (mTag[idx] == (a / 64));
  endfunction

  function automatic void modelFill(input logic [31:0] a);
    int idx;
    idx = modelIdx(a);
    mValid[idx] = 1'b1;
    mTag[idx]   = a / 64;
    mData[idx]  = memWord(a);
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
    end
    expHits   = 0;
    expMisses = 0;
  endfunction

  // Reset with all requests idle; leaves us #1 after a rising edge.
  task automatic applyReset();
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    nRST     = 1'b0;
    modelClear();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic checkCounters(input string name);
    checks++;
    if (hit_count !== 32'(expHits)) begin
      errors++;
      $display("[TB] FAIL %s hit_count got %0d want %0d", name, hit_count, expHits);
    end
    checks++;
    if (miss_count !== 32'(expMisses)) begin
      errors++;
      $display("[TB] FAIL %s miss_count got %0d want %0d", name, miss_count, expMisses);
    end
  endtask

  // One fetch: a hit takes one cycle; a miss takes the lookup cycle plus
  // lat busy cycles plus the data cycle. Ends #1 after the last rising edge.
  task automatic fetchWord(input logic [31:0] a, input int lat);
    bit          expHit;
    logic [31:0] expData;
    logic [31:0] wordAddr;
    expHit   = modelHit(a);
    expData  = mData[modelIdx(a)];
    wordAddr = a & 32'hFFFF_FFFC;
    imemaddr = a;
    imemREN  = 1'b1;
    iwait    = 1'b1;
    @(negedge CLK);
    checks++;
    if (ihit !== expHit) begin
      errors++;
      $display("[TB] FAIL lookup_ihit addr=%h got %b want %b", a, ihit, expHit);
    end
    checks++;
    if (iREN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lookup_iren addr=%h got %b want 0", a, iREN);
    end
    if (expHit) begin
      checks++;
      if (imemload !== expData) begin
        errors++;
        $display("[TB] FAIL hit_data addr=%h got %h want %h", a, imemload, expData);
      end
      expHits++;
      @(posedge CLK);
      #1;
    end else begin
      checks++;
      if (imemload !== 32'h0) begin
        errors++;
        $display("[TB] FAIL miss_data addr=%h got %h want 0", a, imemload);
      end
      expMisses++;
      @(posedge CLK);
      #1;
      for (int k = 0; k <= lat; k++) begin
        if (k == lat) begin
          iwait = 1'b0;
          iload = memWord(a);
        end
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b1 || iaddr !== wordAddr || ihit !== 1'b0) begin
          errors++;
          $display("[TB] FAIL refill addr=%h got iREN=%b iaddr=%h ihit=%b want 1 %h 0",
                   a, iREN, iaddr, ihit, wordAddr);
        end
        @(posedge CLK);
        #1;
      end
      iwait = 1'b1;
      iload = $urandom;
      modelFill(a);
    end
  endtask

  // Miss on oldA, then move the fetch address to newA (and optionally drop
  // imemREN) while the refill is still outstanding.
  task automatic redirectFetch(input logic [31:0] oldA, input logic [31:0] newA,
                               input int lat, input bit dropReq);
    logic [31:0] wordAddr;
    wordAddr = oldA & 32'hFFFF_FFFC;
    imemaddr = oldA;
    imemREN  = 1'b1;
    iwait    = 1'b1;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_miss addr=%h got ihit=%b want 0", oldA, ihit);
    end
    expMisses++;
    @(posedge CLK);
    #1;
    imemaddr = newA;
    if (dropReq) imemREN = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k == lat) begin
        iwait = 1'b0;
        iload = memWord(oldA);
      end
      @(negedge CLK);
      checks++;
      if (iREN !== 1'b1 || iaddr !== wordAddr || ihit !== 1'b0) begin
        errors++;
        $display("[TB] FAIL redirect_refill addr=%h got iREN=%b iaddr=%h ihit=%b want 1 %h 0",
                 oldA, iREN, iaddr, ihit, wordAddr);
      end
      @(posedge CLK);
      #1;
    end
    iwait   = 1'b1;
    imemREN = 1'b1;
    modelFill(oldA);
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    iwait    = 1'b1;
    iload    = '0;
    modelClear();
    #3;
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got ihit=%b iREN=%b iaddr=%h imemload=%h want 0 0 0 0",
               ihit, iREN, iaddr, imemload);
    end
    checkCounters("reset");
    applyReset();
  endtask

  task automatic test_cold_miss();
    applyReset();
    memModel[32'h40 >> 2] = 32'h2008_0001;
    fetchWord(32'h0000_0040, 3);
    imemaddr = 32'h0000_0040;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h2008_0001) begin
      errors++;
      $display("[TB] FAIL cold_rehit got ihit=%b data=%h want 1 20080001", ihit, imemload);
    end
    expHits++;
    @(posedge CLK);
    #1;
    checkCounters("cold_miss");
  endtask

  task automatic test_sequential_fill();
    applyReset();
    for (int i = 0; i < 16; i++) fetchWord(32'(i * 4), $urandom_range(0, 2));
    for (int i = 0; i < 16; i++) fetchWord(32'(i * 4), 0);
    checks++;
    if (miss_count !== 32'd16 || hit_count !== 32'd16) begin
      errors++;
      $display("[TB] FAIL seq_fill counts got miss=%0d hit=%0d want 16 16", miss_count, hit_count);
    end
  endtask

  task automatic test_conflict();
    applyReset();
    fetchWord(32'h10, 1);
    fetchWord(32'h50, 1);
    fetchWord(32'h10, 1);
    checks++;
    if (miss_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL conflict_misses got %0d want 3", miss_count);
    end
    fetchWord(32'h10, 0);
    checkCounters("conflict");
  endtask

  task automatic test_redirect();
    applyReset();
    redirectFetch(32'h80, 32'h200, 2, 1'b0);
    fetchWord(32'h200, 1);
    redirectFetch(32'h80, 32'h84, 1, 1'b1);
    fetchWord(32'h84, 1);
    fetchWord(32'h80, 0);
    checkCounters("redirect");
  endtask

  task automatic test_async_reset();
    imemaddr = 32'h0000_00C0;
    imemREN  = 1'b1;
    iwait    = 1'b1;
    @(posedge CLK);
    #2;
    checks++;
    if (iREN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre_iren got %b want 1", iREN);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got iREN=%b iaddr=%h ihit=%b want 0 0 0", iREN, iaddr, ihit);
    end
    modelClear();
    checkCounters("async_reset");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    fetchWord(32'h80, 1);
    checkCounters("after_async_reset");
  endtask

  task automatic test_ren_low();
    int hitsBefore;
    int missesBefore;
    hitsBefore   = expHits;
    missesBefore = expMisses;
    imemREN      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imemaddr = (i == 0) ? 32'h80 : 32'($urandom_range(0, 255) * 4);
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ren_low addr=%h got ihit=%b iREN=%b want 0 0", imemaddr, ihit, iREN);
      end
      @(posedge CLK);
      #1;
    end
    checks++;
    if (hit_count !== 32'(hitsBefore) || miss_count !== 32'(missesBefore)) begin
      errors++;
      $display("[TB] FAIL ren_low_counters got %0d/%0d want %0d/%0d",
               hit_count, miss_count, hitsBefore, missesBefore);
    end
    imemREN = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    applyReset();
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0 && !modelHit(a)) begin
        b = 32'($urandom_range(0, 127) * 4);
        redirectFetch(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        fetchWord(b, $urandom_range(0, 3));
      end else begin
        fetchWord(a, $urandom_range(0, 3));
      end
    end
    checkCounters("random");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_miss();
    test_sequential_fill();
    test_conflict();
    test_redirect();
    test_async_reset();
    test_ren_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller.
- Supplies the `imemREN`/`imemaddr` → `ihit`/`imemload` side of the datapath-cache interface.
- Issues single-word refills on the controller-facing `iREN`/`iaddr`/`iwait`/`iload` side.
- Hits complete combinationally in the same cycle; misses stall fetch via `ihit`=0 until the refill lands.

Parameters:
- SETS, 16, number of one-word frames; power of two, 2..256.
- IDX_W, $clog2(SETS), index width.
- TAG_W, 30-IDX_W, tag width (2-bit byte offset is ignored).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; word-aligned, bits [1:0] ignored.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  refill read request to memory controller.
- iaddr  out  32  refill address, {imemaddr[31:2],2'b00} latched at miss.
- iwait  in  1  controller busy; refill data valid in the cycle iwait=0 while iREN=1.
- iload  in  32  refill data.
- hit_count  out  32  saturating count of hit cycles (performance).
- miss_count  out  32  saturating count of misses taken.

Behaviour:
- Address split: tag=imemaddr[31:2+IDX_W], idx=imemaddr[1+IDX_W:2].
- Storage per frame: valid, tag[TAG_W], data[32].
- Reset (async, nRST=0):
  - All valid bits cleared; state=IDLE; counters=0.
  - Outputs ihit=0, iREN=0, iaddr=0, imemload=0 immediately.
  - Reset mid-refill abandons the refill with no frame written.
- State IDLE:
  - hit = imemREN & valid[idx] & tag match.
  - ihit=hit; imemload=data[idx] when hit, else 0.
  - On imemREN & !hit: latch miss_addr={imemaddr[31:2],2'b00}, increment miss_count, go to FETCH.
  - Each cycle with ihit=1 increments hit_count.
- State FETCH:
  - iREN=1; iaddr=miss_addr; ihit=0.
  - When iwait=0: write frame[miss_addr idx] = {1, miss tag, iload}, go to IDLE.
  - The next cycle re-looks up and hits if imemaddr is unchanged, so miss latency = controller latency + 1 cycle.
- Requester changes mid-refill:
  - If imemaddr changes during FETCH (branch/jump redirect from the memory stage), the refill completes for miss_addr anyway (no abort).
  - The new address is looked up in IDLE afterward.
  - If imemREN falls during FETCH, the refill still completes.
- Refill data is never forwarded to ihit in the FETCH cycle; hit is only from stored frames.
- Conflict: a miss to an occupied index overwrites that frame (no replacement choice).
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- Cache is never written by the datapath; there is no flush and halt has no effect.
- Outputs iREN and iaddr are registered-state-derived: no combinational path from imemaddr to iREN.

Decomposition:
- cpu_types_pkg additions:
  - `icache_addr_t` packed struct {tag, idx, bytoff[1:0]}.
  - `icache_frame_t` {valid, tag, data}.
  - `icache_state_t` enum {IDLE, FETCH}.
- The shared package uses the default SETS=16, so tag is 26 bits and idx is 4 bits.
- One sub-module: `sat_counter32` (enable, saturating 32-bit counter), instantiated twice.

Test Plan:
1. Cold miss then hit:
   - Stimulus: reset, imemREN=1, imemaddr=0x0000_0040, controller holds iwait=1 for 3 cycles then 0 with iload=0x2008_0001.
   - Required: iREN=1 and iaddr=0x40 for 4 cycles; the next cycle ihit=1, imemload=0x2008_0001; miss_count=1, hit_count=1.
2. Sequential fill:
   - Stimulus: addresses 0x00,0x04,…,0x3C fetched once, then all 16 refetched.
   - Required: 16 misses, then 16 single-cycle hits with correct data; miss_count=16, hit_count=16 after the second pass.
3. Conflict eviction:
   - Stimulus: fill 0x0000_0010, then fetch 0x0000_0050 (same idx 4, different tag), then 0x10 again.
   - Required: 3 misses total; the final data equals memory at 0x10.
4. Redirect mid-refill:
   - Stimulus: miss on 0x80; imemaddr switches to 0x200 during FETCH.
   - Required: iaddr stays 0x80 until iwait=0; frame idx 0 holds the 0x80 tag; a new miss is issued for 0x200 one cycle later.
5. Async reset mid-refill:
   - Stimulus: assert nRST=0 while in FETCH with iwait=1.
   - Required: iREN falls without waiting for a clock; after release, fetch of 0x80 misses again (valid cleared).
6. imemREN low:
   - Stimulus: imemREN=0 at any address, including a valid one.
   - Required: ihit=0, iREN=0, counters unchanged.
